// File: rtl/truth_table_sweeper_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : sweep_pkg
// Purpose  : Shared definitions for the truth-table sweeper: controller state
//            encoding and the legal ranges of the sweep parameters.
// Ports    : none (package)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
package sweep_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRIVE = 2'd1,
      ST_DONE  = 2'd2
   } sweep_state_t;

   localparam int unsigned C_N_IN_MIN   = 1;
   localparam int unsigned C_N_IN_MAX   = 8;
   localparam int unsigned C_HOLD_MIN   = 1;
   localparam int unsigned C_HOLD_MAX   = 255;
   // Wide enough for HOLD-1 at the top of the legal HOLD range.
   localparam int unsigned C_HOLD_CNT_W = 8;

endpackage : sweep_pkg
`default_nettype wire

// File: rtl/truth_table_sweeper_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : truth_table_sweeper_if
// Purpose  : Bundles the sweep request/abort controls, the response of the
//            circuit under test and the sweeper results.
// Ports    : master - drives start, abort, dut_out; observes results
//            slave  - the sweeper itself
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
interface truth_table_sweeper_if #(
   parameter int N_IN = 3
) ();
   logic                 start;
   logic                 abort;
   logic                 dut_out;
   logic [N_IN-1:0]      vec_out;
   logic                 busy;
   logic                 done;
   logic                 pass;
   logic [N_IN:0]        err_count;
   logic [2**N_IN-1:0]   obs_table;

   modport master (
      output start, abort, dut_out,
      input  vec_out, busy, done, pass, err_count, obs_table
   );

   modport slave (
      input  start, abort, dut_out,
      output vec_out, busy, done, pass, err_count, obs_table
   );
endinterface : truth_table_sweeper_if
`default_nettype wire

// File: rtl/truth_table_sweeper_hold_timer.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : hold_timer
// Purpose  : Counts the cycles a stimulus vector has been held, 0..HOLD-1,
//            wrapping back to 0 after the last hold cycle.
// Ports    : clk   - clock
//            rst_n - asynchronous active-low reset
//            clr   - force count to 0
//            en    - advance the count
//            last  - count is at HOLD-1 (final, settled hold cycle)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module hold_timer
   import sweep_pkg::*;
#(
   parameter int HOLD = 20
) (
   input  wire logic clk,
   input  wire logic rst_n,
   input  wire logic clr,
   input  wire logic en,
   output logic      last
);

   localparam logic [C_HOLD_CNT_W-1:0] c_last_cnt = C_HOLD_CNT_W'(HOLD - 1);

   logic [C_HOLD_CNT_W-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (clr) begin
         r_cnt <= '0;
      end else if (en) begin
         r_cnt <= (r_cnt == c_last_cnt) ? '0 : r_cnt + C_HOLD_CNT_W'(1);
      end
   end

   assign last = (r_cnt == c_last_cnt);

endmodule : hold_timer
`default_nettype wire

// File: rtl/truth_table_sweeper.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : truth_table_sweeper
// Purpose  : Exhaustively drives every input vector to a combinational circuit
//            under test, holds each for HOLD cycles, samples the response on
//            the last hold cycle and compares it against EXPECTED.
// Ports    : clk   - clock, rising edge
//            rst_n - asynchronous active-low reset
//            sw    - slave side of truth_table_sweeper_if
//                    (start, abort, dut_out in; vec_out, busy, done, pass,
//                     err_count, obs_table out, all registered)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module truth_table_sweeper
   import sweep_pkg::*;
#(
   parameter int                  N_IN     = 3,
   parameter int                  HOLD     = 20,
   parameter logic [2**N_IN-1:0]  EXPECTED = 8'b1000_0000
) (
   input  wire logic               clk,
   input  wire logic               rst_n,
   truth_table_sweeper_if.slave    sw
);

   if (N_IN < int'(C_N_IN_MIN) || N_IN > int'(C_N_IN_MAX)) begin : g_bad_n_in
      $error("truth_table_sweeper: N_IN out of range");
   end
   if (HOLD < int'(C_HOLD_MIN) || HOLD > int'(C_HOLD_MAX)) begin : g_bad_hold
      $error("truth_table_sweeper: HOLD out of range");
   end

   localparam logic [N_IN-1:0] c_last_vec = '1;

   sweep_state_t          r_state, w_state_nxt;
   logic [N_IN-1:0]       r_vec, w_vec_nxt;
   logic [N_IN:0]         r_err, w_err_nxt;
   logic [2**N_IN-1:0]    r_obs, w_obs_nxt;
   logic                  r_busy, r_done, r_pass;
   logic                  w_tmr_clr, w_tmr_en, w_last;

   hold_timer #(.HOLD(HOLD)) u_hold_timer (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (w_tmr_clr),
      .en    (w_tmr_en),
      .last  (w_last)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_vec   <= '0;
         r_err   <= '0;
         r_obs   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_pass  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_vec   <= w_vec_nxt;
         r_err   <= w_err_nxt;
         r_obs   <= w_obs_nxt;
         // Status flags are registered from the next state so they line up
         // with the state they describe.
         r_busy  <= (w_state_nxt == ST_DRIVE);
         r_done  <= (w_state_nxt == ST_DONE);
         r_pass  <= (w_state_nxt == ST_DONE) && (w_err_nxt == '0);
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_vec_nxt   = r_vec;
      w_err_nxt   = r_err;
      w_obs_nxt   = r_obs;
      w_tmr_clr   = 1'b0;
      w_tmr_en    = 1'b0;
      case (r_state)
         ST_IDLE, ST_DONE: begin
            if (sw.start) begin
               w_state_nxt = ST_DRIVE;
               w_vec_nxt   = '0;
               w_err_nxt   = '0;
               w_obs_nxt   = '0;
               w_tmr_clr   = 1'b1;
            end
         end
         ST_DRIVE: begin
            // Abort wins over a sample/advance falling on the same edge;
            // partial results are kept.
            if (sw.abort) begin
               w_state_nxt = ST_IDLE;
               w_vec_nxt   = '0;
               w_tmr_clr   = 1'b1;
            end else begin
               w_tmr_en = 1'b1;
               if (w_last) begin
                  w_obs_nxt[r_vec] = sw.dut_out;
                  // At most 2**N_IN increments, so N_IN+1 bits never wrap.
                  if (sw.dut_out != EXPECTED[r_vec]) begin
                     w_err_nxt = r_err + (N_IN + 1)'(1);
                  end
                  if (r_vec == c_last_vec) begin
                     w_state_nxt = ST_DONE;
                  end else begin
                     w_vec_nxt = r_vec + N_IN'(1);
                  end
               end
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_vec_nxt   = '0;
            w_tmr_clr   = 1'b1;
         end
      endcase
   end

   assign sw.vec_out   = r_vec;
   assign sw.busy      = r_busy;
   assign sw.done      = r_done;
   assign sw.pass      = r_pass;
   assign sw.err_count = r_err;
   assign sw.obs_table = r_obs;

endmodule : truth_table_sweeper
`default_nettype wire

// File: tb/tb_truth_table_sweeper.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_truth_table_sweeper
// Purpose  : Self-checking bench for truth_table_sweeper. Instance A uses the
//            default AND-3 setup and is tracked every cycle by a time-based
//            reference model; instance B is the 1-input inverter case.
// Ports    : none
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_truth_table_sweeper;

   localparam int HOLD_A = 20;
   localparam int NVEC_A = 8;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   mode  = 0;   // 0: AND3, 1: stuck-at-1, 2: per-cycle noise

   int n_pass  = 0;
   int n_total = 0;

   truth_table_sweeper_if #(.N_IN(3)) ifa ();
   truth_table_sweeper_if #(.N_IN(1)) ifb ();

   truth_table_sweeper #(.N_IN(3), .HOLD(HOLD_A), .EXPECTED(8'b1000_0000)) u_dut_a (
      .clk   (clk),
      .rst_n (rst_n),
      .sw    (ifa)
   );

   truth_table_sweeper #(.N_IN(1), .HOLD(1), .EXPECTED(2'b01)) u_dut_b (
      .clk   (clk),
      .rst_n (rst_n),
      .sw    (ifb)
   );

   always #5 clk = ~clk;

   // Circuits under test: response settles shortly after the vector changes.
   always @(posedge clk) begin
      #1;
      case (mode)
         0:       ifa.dut_out = &ifa.vec_out;
         1:       ifa.dut_out = 1'b1;
         default: ifa.dut_out = 1'($urandom_range(0, 1));
      endcase
      ifb.dut_out = ~ifb.vec_out[0];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp)
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      else
         n_pass++;
   endtask

   // Reference model: time since the start edge determines the vector; the
   // response is sampled on the final cycle of each HOLD window.
   bit       m_active = 1'b0;
   bit       m_done   = 1'b0;
   int       m_t      = 0;
   int       m_err    = 0;
   bit [7:0] m_obs    = '0;
   int       m_v;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_active = 1'b0;
         m_done   = 1'b0;
         m_t      = 0;
         m_err    = 0;
         m_obs    = '0;
      end else if (m_active) begin
         if (ifa.abort) begin
            m_active = 1'b0;
         end else begin
            m_v = m_t / HOLD_A;
            if (m_t % HOLD_A == HOLD_A - 1) begin
               m_obs[m_v] = ifa.dut_out;
               if (ifa.dut_out != (m_v == NVEC_A - 1)) m_err++;
               if (m_v == NVEC_A - 1) begin
                  m_active = 1'b0;
                  m_done   = 1'b1;
               end
            end
            m_t++;
         end
      end else if (ifa.start) begin
         m_active = 1'b1;
         m_done   = 1'b0;
         m_t      = 0;
         m_err    = 0;
         m_obs    = '0;
      end
   end

   always @(negedge clk) begin
      chk("vec_out",   32'(ifa.vec_out),   m_active ? 32'(m_t / HOLD_A) : (m_done ? 32'd7 : 32'd0));
      chk("busy",      32'(ifa.busy),      32'(m_active));
      chk("done",      32'(ifa.done),      32'(m_done));
      chk("pass",      32'(ifa.pass),      32'(m_done && m_err == 0));
      chk("err_count", 32'(ifa.err_count), 32'(m_err));
      chk("obs_table", 32'(ifa.obs_table), 32'(m_obs));
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic launch();
      ifa.start = 1'b1;
      step();
      ifa.start = 1'b0;
   endtask

   // Called just after the start edge; k counts edges since that edge.
   task automatic wait_done(input int restart_at, input int abort_at, output int lat);
      lat = -1;
      for (int k = 1; k <= 400; k++) begin
         if (k == restart_at) ifa.start = 1'b1;
         if (k == abort_at)   ifa.abort = 1'b1;
         step();
         ifa.start = 1'b0;
         ifa.abort = 1'b0;
         if (k == abort_at) break;
         if (ifa.done) begin
            lat = k;
            break;
         end
      end
   endtask

   int lat;

   initial begin
      ifa.start = 1'b0; ifa.abort = 1'b0; ifa.dut_out = 1'b0;
      ifb.start = 1'b0; ifb.abort = 1'b0; ifb.dut_out = 1'b0;
      repeat (3) step();
      chk("rst vec_out",   32'(ifa.vec_out),   32'd0);
      chk("rst busy",      32'(ifa.busy),      32'd0);
      chk("rst done",      32'(ifa.done),      32'd0);
      chk("rst pass",      32'(ifa.pass),      32'd0);
      chk("rst err_count", 32'(ifa.err_count), 32'd0);
      chk("rst obs_table", 32'(ifa.obs_table), 32'd0);
      rst_n = 1'b1;
      step();

      // AND3 reference circuit, with a start re-pulse mid-sweep.
      mode = 0;
      launch();
      wait_done(50, 0, lat);
      chk("and3 latency", 32'(lat), 32'd160);
      chk("and3 pass",    32'(ifa.pass), 32'd1);
      chk("and3 err",     32'(ifa.err_count), 32'd0);
      chk("and3 obs",     32'(ifa.obs_table), 32'h80);
      chk("and3 vec",     32'(ifa.vec_out), 32'd7);

      // Abort in DONE has no effect.
      ifa.abort = 1'b1;
      step();
      ifa.abort = 1'b0;
      step();
      chk("abort in done", 32'(ifa.done), 32'd1);

      // Stuck-at-1 output.
      mode = 1;
      launch();
      wait_done(0, 0, lat);
      chk("sa1 latency", 32'(lat), 32'd160);
      chk("sa1 err",     32'(ifa.err_count), 32'd7);
      chk("sa1 pass",    32'(ifa.pass), 32'd0);
      chk("sa1 obs",     32'(ifa.obs_table), 32'hFF);

      // Restart straight from DONE clears results.
      mode = 0;
      launch();
      chk("restart err",  32'(ifa.err_count), 32'd0);
      chk("restart vec",  32'(ifa.vec_out), 32'd0);
      chk("restart busy", 32'(ifa.busy), 32'd1);
      chk("restart done", 32'(ifa.done), 32'd0);
      wait_done(0, 0, lat);
      chk("restart latency", 32'(lat), 32'd160);

      // Abort at edge 45 (vector 2, hold 4) with stuck-at-1.
      mode = 1;
      launch();
      wait_done(0, 45, lat);
      chk("abort vec",  32'(ifa.vec_out), 32'd0);
      chk("abort done", 32'(ifa.done), 32'd0);
      chk("abort busy", 32'(ifa.busy), 32'd0);
      chk("abort err",  32'(ifa.err_count), 32'd2);
      chk("abort obs",  32'(ifa.obs_table), 32'h03);

      // Asynchronous reset mid-sweep.
      mode = 0;
      launch();
      repeat (69) step();
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst vec_out",   32'(ifa.vec_out),   32'd0);
      chk("arst busy",      32'(ifa.busy),      32'd0);
      chk("arst done",      32'(ifa.done),      32'd0);
      chk("arst pass",      32'(ifa.pass),      32'd0);
      chk("arst err_count", 32'(ifa.err_count), 32'd0);
      chk("arst obs_table", 32'(ifa.obs_table), 32'd0);
      step();
      step();
      rst_n = 1'b1;
      step();
      launch();
      wait_done(0, 0, lat);
      chk("post-rst latency", 32'(lat), 32'd160);
      chk("post-rst pass",    32'(ifa.pass), 32'd1);

      // Random start/abort traffic against a noisy response.
      mode = 2;
      for (int i = 0; i < 3000; i++) begin
         ifa.start = ($urandom_range(0, 39) == 0);
         ifa.abort = ($urandom_range(0, 149) == 0);
         step();
      end
      ifa.start = 1'b0;
      ifa.abort = 1'b0;
      step();

      // Inverter: one input, one-cycle hold.
      ifb.start = 1'b1;
      step();
      ifb.start = 1'b0;
      lat = -1;
      for (int k = 1; k <= 20; k++) begin
         step();
         if (ifb.done) begin
            lat = k;
            break;
         end
      end
      chk("inv latency", 32'(lat), 32'd2);
      chk("inv pass",    32'(ifb.pass), 32'd1);
      chk("inv err",     32'(ifb.err_count), 32'd0);
      chk("inv obs",     32'(ifb.obs_table), 32'h1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule : tb_truth_table_sweeper
`default_nettype wire

// File: doc/truth_table_sweeper.md
TRUTH_TABLE_SWEEPER -- requirements
Module: truth_table_sweeper

Interface
REQ-001 SHALL have parameter N_IN, default 3: number of DUT input bits; legal range 1..8.
REQ-002 SHALL have parameter HOLD, default 20: clock cycles each vector is held; legal range 1..255.
REQ-003 SHALL have parameter EXPECTED, width 2**N_IN, default 8'b1000_0000 (AND-3): bit k is the expected DUT output for vector k.
REQ-004 SHALL have port clk  input  1: single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1: reset, asynchronous, active-low.
REQ-006 SHALL have port start  input  1: sweep request, sampled on rising edge.
REQ-007 SHALL have port abort  input  1: synchronous stop of the current sweep.
REQ-008 SHALL have port dut_out  input  1: response of the circuit under test.
REQ-009 SHALL have port vec_out  output  N_IN: stimulus vector driven to the DUT; MSB = first DUT input.
REQ-010 SHALL have port busy  output  1: high in DRIVE state.
REQ-011 SHALL have port done  output  1: high in DONE state.
REQ-012 SHALL have port pass  output  1: high in DONE when err_count==0.
REQ-013 SHALL have port err_count  output  N_IN+1: number of mismatching vectors in the current or last sweep.
REQ-014 SHALL have port obs_table  output  2**N_IN: captured DUT response; bit k = dut_out sampled for vector k.

Function
REQ-015 SHALL implement FSM states IDLE, DRIVE, DONE.
REQ-016 IDLE: start=1 -> DRIVE; on that edge vec_out<=0, hold_cnt<=0, err_count<=0, obs_table<=0.
REQ-017 DRIVE: hold_cnt increments each cycle, 0..HOLD-1; vec_out is stable for exactly HOLD cycles per vector.
REQ-018 DRIVE, hold_cnt==HOLD-1: dut_out is sampled into obs_table[vec_out]; err_count increments if dut_out != EXPECTED[vec_out]; sampling occurs only on this last hold cycle, to allow settling.
REQ-019 At that same edge: if vec_out==2**N_IN-1 -> DONE with vec_out held; else vec_out<=vec_out+1, hold_cnt<=0.
REQ-020 Sweep latency from start edge to done high SHALL be exactly HOLD*2**N_IN cycles.
REQ-021 start while in DRIVE SHALL be ignored.
REQ-022 DONE: done, pass, err_count and obs_table hold until start=1, which restarts as in REQ-016 (DONE->DRIVE directly).
REQ-023 abort=1 in DRIVE -> IDLE next edge; vec_out<=0; err_count/obs_table keep partial values; done not asserted. abort has priority over the sample/advance of REQ-018/019 on the same edge.
REQ-024 abort in IDLE or DONE SHALL have no effect.
REQ-025 err_count SHALL NOT wrap; max value 2**N_IN fits its width by construction.
REQ-026 vec_out increment SHALL never wrap; the terminal vector ends the sweep.
REQ-027 pass SHALL be 0 outside DONE.

Reset
REQ-028 rst_n low SHALL immediately force: state IDLE, vec_out 0, hold_cnt 0, err_count 0, obs_table 0, busy 0, done 0, pass 0.
REQ-029 Reset mid-sweep SHALL discard all progress; the first start after deassertion begins at vector 0.

Structure
REQ-030 State encoding enum (IDLE/DRIVE/DONE) and the N_IN/HOLD legal-range constants SHALL live in shared package sweep_pkg.
REQ-031 The hold counter SHALL be a sub-module hold_timer (parameter HOLD; ports clk, rst_n, clr, en, last).
REQ-032 All outputs SHALL be registered; no combinational path from dut_out to any output.

Verification
REQ-033 N_IN=3, HOLD=20, DUT=AND3, start pulse -> vec_out 0..7, each held 20 cycles; done at cycle 160; pass=1; err_count=0; obs_table=8'h80.
REQ-034 Same setup, dut_out stuck-at-1 -> done at 160; err_count=7; pass=0; obs_table=8'hFF.
REQ-035 abort asserted on the cycle-45 edge (vector 2, hold_cnt 4) -> IDLE; vec_out=0; done=0; err_count/obs_table reflect vectors 0..1 only.
REQ-036 rst_n pulsed low at cycle 70 -> all outputs 0 immediately, asynchronously; a new start yields a full 160-cycle sweep.
REQ-037 start re-pulsed during DRIVE -> no effect on timing; done still at 160; start in DONE -> restart at vector 0 with err_count cleared.
REQ-038 N_IN=1, HOLD=1, EXPECTED=2'b01 (inverter) -> done 2 cycles after start; pass=1.
